// File: rtl/stream_byte_packer.sv
// Packs a byte-wide sop/eop packet stream into DATA_WIDTH-wide words, first byte in the MSB lane.
// Optional STREAM_BYTE_PACKER_ERR_CNT_EN adds a saturating protocol-violation counter (err_count/err_clear).
module stream_byte_packer #(
    parameter  int DATA_WIDTH  = 32,
    localparam int EMPTY_WIDTH = $clog2(DATA_WIDTH/8)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty
`ifdef STREAM_BYTE_PACKER_ERR_CNT_EN
    ,
    output logic [15:0]            err_count,
    input  logic                   err_clear
`endif
);

    localparam int N = DATA_WIDTH / 8;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state_reg, state_next;
    logic [EMPTY_WIDTH-1:0] lane_reg, lane_next;
    logic                   sop_pending_reg, sop_pending_next;
    logic [DATA_WIDTH-1:0]  acc_reg, acc_next;

    logic                   out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0]  out_data_reg, out_data_next;
    logic                   out_sop_reg, out_sop_next;
    logic                   out_eop_reg, out_eop_next;
    logic [EMPTY_WIDTH-1:0] out_empty_reg, out_empty_next;

    logic                   accept;
    logic                   start;
    logic                   write;
    logic [EMPTY_WIDTH-1:0] lane_sel;
    logic                   complete;
    logic [DATA_WIDTH-1:0]  word;

    assign in_ready  = reset && (!out_valid_reg || out_ready);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sop   = out_sop_reg;
    assign out_eop   = out_eop_reg;
    assign out_empty = out_empty_reg;

    // Bytes with the wrong sop for the current state are dropped without touching packet state.
    assign accept   = in_valid && in_ready;
    assign start    = accept && (state_reg == IDLE) && in_sop;
    assign write    = accept && ((state_reg == IDLE) ? in_sop : !in_sop);
    assign lane_sel = (state_reg == IDLE) ? '0 : lane_reg;
    assign complete = write && (in_eop || (lane_sel == EMPTY_WIDTH'(N-1)));

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign word[DATA_WIDTH-1-8*gi -: 8] =
                (write && (lane_sel == EMPTY_WIDTH'(gi))) ? in_data : acc_reg[DATA_WIDTH-1-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        lane_next        = lane_reg;
        sop_pending_next = sop_pending_reg;
        acc_next         = acc_reg;
        out_valid_next   = out_valid_reg;
        out_data_next    = out_data_reg;
        out_sop_next     = out_sop_reg;
        out_eop_next     = out_eop_reg;
        out_empty_next   = out_empty_reg;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (complete) begin
            // A new word overwrites the register on the same edge as a handshake, so no bubble.
            out_valid_next   = 1'b1;
            out_data_next    = word;
            out_sop_next     = start || sop_pending_reg;
            out_eop_next     = in_eop;
            out_empty_next   = in_eop ? (EMPTY_WIDTH'(N-1) - lane_sel) : '0;
            sop_pending_next = 1'b0;
            lane_next        = '0;
            acc_next         = '0;
            state_next       = in_eop ? IDLE : IN_PKT;
        end else if (write) begin
            acc_next   = word;
            lane_next  = lane_sel + EMPTY_WIDTH'(1);
            state_next = IN_PKT;
            if (start) begin
                sop_pending_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            lane_reg        <= '0;
            sop_pending_reg <= 1'b0;
            acc_reg         <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_sop_reg     <= 1'b0;
            out_eop_reg     <= 1'b0;
            out_empty_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            lane_reg        <= lane_next;
            sop_pending_reg <= sop_pending_next;
            acc_reg         <= acc_next;
            out_valid_reg   <= out_valid_next;
            out_data_reg    <= out_data_next;
            out_sop_reg     <= out_sop_next;
            out_eop_reg     <= out_eop_next;
            out_empty_reg   <= out_empty_next;
        end
    end

`ifdef STREAM_BYTE_PACKER_ERR_CNT_EN
    logic        err;
    logic [15:0] err_count_reg;

    assign err       = accept && !write;
    assign err_count = err_count_reg;

    // Clear has priority over a same-cycle violation; the count saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_reg <= '0;
        end else if (err_clear) begin
            err_count_reg <= '0;
        end else if (err && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed bench for stream_byte_packer (DATA_WIDTH=32): scoreboarded output words plus timing/state checks.
// Build with STREAM_BYTE_PACKER_ERR_CNT_EN defined to also exercise err_count/err_clear.
module tb_stream_byte_packer;

    localparam int DW = 32;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_sop;
    logic          in_eop;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
`ifdef STREAM_BYTE_PACKER_ERR_CNT_EN
    logic [15:0]   err_count;
    logic          err_clear;
`endif

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    bit track_stall = 1'b0;

    logic [DW-1:0] got_data[$];
    logic [3:0]    got_flags[$];
    logic [DW-1:0] exp_data[$];
    logic [3:0]    exp_flags[$];

    stream_byte_packer #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_empty (out_empty)
`ifdef STREAM_BYTE_PACKER_ERR_CNT_EN
        ,
        .err_count (err_count),
        .err_clear (err_clear)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Handshake happens at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_flags.push_back({out_sop, out_eop, out_empty});
            $display("word %0d: data=%08h sop=%0b eop=%0b empty=%0d",
                     got_data.size(), out_data, out_sop, out_eop, out_empty);
        end
        if (track_stall && in_valid && !in_ready) stalls++;
    end

    task automatic expect_word(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] emp);
        exp_data.push_back(d);
        exp_flags.push_back({s, e, emp});
    endtask

    // Leaves in_valid asserted on return so consecutive calls drive back-to-back bytes.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 200) begin
                check("send_timeout", 64'(d), 64'hFFFF);
                break;
            end
        end
    endtask

    task automatic drop_valid();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = 1'b1;
`ifdef STREAM_BYTE_PACKER_ERR_CNT_EN
        err_clear = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_sop",   64'(out_sop),   64'd0);
        check("rst_out_eop",   64'(out_eop),   64'd0);
        check("rst_out_empty", 64'(out_empty), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
`ifdef STREAM_BYTE_PACKER_ERR_CNT_EN
        check("rst_err_count", 64'(err_count), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate 8-byte packet
        expect_word(32'h01020304, 1'b1, 1'b0, 2'd0);
        expect_word(32'h05060708, 1'b0, 1'b1, 2'd0);
        track_stall = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 1, i == 8);
        drop_valid();
        track_stall = 1'b0;
        check("full_rate_stalls", 64'(stalls), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // 6-byte packet, eop word one cycle after last byte
        expect_word(32'hA1A2A3A4, 1'b1, 1'b0, 2'd0);
        expect_word(32'hA5A60000, 1'b0, 1'b1, 2'd2);
        for (int i = 1; i <= 6; i++) send_byte(8'hA0 + 8'(i), i == 1, i == 6);
        check("a6_lat_valid", 64'(out_valid), 64'd1);
        check("a6_lat_data",  64'(out_data),  64'hA5A60000);
        check("a6_lat_empty", 64'(out_empty), 64'd2);
        drop_valid();
        repeat (2) @(posedge clk);
        #1;

        // Single-byte packet
        expect_word(32'h5C000000, 1'b1, 1'b1, 2'd3);
        send_byte(8'h5C, 1'b1, 1'b1);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_flags", 64'({out_sop, out_eop, out_empty}), 64'b1111);
        drop_valid();
        repeat (2) @(posedge clk);
        #1;

        // Backpressure for 10 cycles
        expect_word(32'hB1B2B3B4, 1'b1, 1'b0, 2'd0);
        expect_word(32'hB5B6B7B8, 1'b0, 1'b1, 2'd0);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send_byte(8'hB0 + 8'(i), i == 1, i == 8);
                drop_valid();
            end
            begin
                int k;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!out_valid && k < 50);
                check("bp_word_loaded", 64'(out_valid), 64'd1);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_hold_data", 64'(out_data), 64'hB1B2B3B4);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Protocol violations: stray byte in IDLE, stray sop mid-packet
        expect_word(32'h22232425, 1'b1, 1'b1, 2'd0);
        send_byte(8'h11, 1'b0, 1'b0);
        drop_valid();
        @(posedge clk);
        #1;
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h23, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h24, 1'b0, 1'b0);
        send_byte(8'h25, 1'b0, 1'b1);
        drop_valid();
        repeat (2) @(posedge clk);
        #1;
`ifdef STREAM_BYTE_PACKER_ERR_CNT_EN
        check("err_count_two", 64'(err_count), 64'd2);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("err_count_clear", 64'(err_count), 64'd0);
`endif

        // Reset mid-packet, then a clean 4-byte packet
        expect_word(32'h0A0B0C0D, 1'b1, 1'b1, 2'd0);
        send_byte(8'h31, 1'b1, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        drop_valid();
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_hold_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_byte(8'h0A + 8'(i), i == 0, i == 3);
        drop_valid();
        repeat (4) @(posedge clk);
        #1;

        check("word_count", 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("word%0d_data", i), 64'(got_data[i]), 64'(exp_data[i]));
            check($sformatf("word%0d_flags", i), 64'(got_flags[i]), 64'(exp_flags[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_byte_packer.md
Name: stream_byte_packer

Overview:
- Upstream neighbour of the stream matching engine.
- Packs a byte-wide packet stream from the receive front end into DATA_WIDTH-wide words on a valid/ready packet stream with sop/eop/empty.
- The matcher consumes this output through its stream_in interface and takes its width from DATA_WIDTH.
- Internally: one accumulator word plus one output register, giving 1 byte/cycle sustained throughput.

Parameters:
- DATA_WIDTH, 32, output word width in bits; must be a multiple of 8 and at least 16; N = DATA_WIDTH/8 byte lanes.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), width of out_empty; localparam, derived.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  input byte.
- in_sop  in  1  first byte of packet.
- in_eop  in  1  last byte of packet.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts word when out_valid && out_ready.
- out_data  out  DATA_WIDTH  packed word; first byte of word in bits [DATA_WIDTH-1:DATA_WIDTH-8].
- out_sop  out  1  word holds first byte of packet.
- out_eop  out  1  word holds last byte of packet.
- out_empty  out  EMPTY_WIDTH  count of unused low-order lanes; valid only with out_eop, otherwise 0.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: out_valid=0, out_data=0, out_sop=0, out_eop=0, out_empty=0.
  - Internal state: accumulator cleared, lane=0, in_pkt=0, sop_pending=0.
  - in_ready is 0 while reset is asserted.
- Reset mid-packet: the partial packet is lost; no word is emitted for it after release.
- in_ready = !out_valid || out_ready. It is combinational and independent of in_valid and in_data.
- State: in_pkt (IDLE/IN_PKT), lane counter 0..N-1, sop_pending flag.
- Accepted byte in IDLE with in_sop=1:
  - byte goes to lane 0; sop_pending=1; in_pkt=1.
  - If in_eop is also 1, this is a single-byte packet; the word completes immediately.
- Accepted byte in IDLE with in_sop=0: dropped (protocol violation V1). State is unchanged.
- Accepted byte in IN_PKT with in_sop=1: dropped (violation V2). The packet continues; lane and accumulator are unchanged.
- Accepted byte in IN_PKT with in_sop=0: written into the current lane.
- Byte lane b occupies out_data[DATA_WIDTH-1-8b -: 8]. Unused lanes of a short final word are zero.
- A word completes when the accepted byte lands in lane N-1, or when it carries in_eop (in_eop is honoured only on bytes that are not dropped).
- On completion:
  - The output register loads the word on the same clock edge, so out_valid rises the next cycle (latency 1 cycle from the completing byte).
  - out_sop = sop_pending; sop_pending is then cleared.
  - On eop: out_eop=1, out_empty = N-1-lane, in_pkt=0.
  - lane resets to 0; the accumulator is cleared.
- The output register holds data and flags stable while out_valid && !out_ready.
- The register clears to out_valid=0 after a handshake unless a new word loads on that same edge.
- Simultaneous handshake and new completion: the new word replaces the old one with no bubble.
- Full-rate operation: back-to-back bytes with out_ready held at 1 produce one word every N cycles and never deassert in_ready.
- Exact-multiple packet: in_eop on lane N-1 gives out_eop=1, out_empty=0.
- A packet of length 1..N produces a single word with out_sop=out_eop=1.

Optional Feature:
- Macro: STREAM_BYTE_PACKER_ERR_CNT_EN.
- When defined:
  - Adds output port err_count, 16 bits, reset 0.
  - err_count increments by 1 on each accepted V1 or V2 byte and saturates at 16'hFFFF.
  - Adds input err_clear, 1 bit; when high it synchronously zeroes err_count, and clearing wins over a same-cycle increment.
- When undefined: neither port exists. Violation handling (the byte is dropped) is identical.

Test Plan (DATA_WIDTH=32):
- Bytes 01..08 back-to-back, sop on 01, eop on 08, out_ready=1 → words 01020304 (sop=1, eop=0) and 05060708 (sop=0, eop=1, empty=0); in_ready stays 1 throughout.
- 6-byte packet A1..A6 → words A1A2A3A4 (sop), A5A60000 (eop, empty=2); the eop word appears 1 cycle after A6 is accepted.
- Single byte 5C with sop=eop=1 → one word 5C000000, sop=1, eop=1, empty=3.
- out_ready=0 for 10 cycles while a second word completes → in_ready=0 after the first word is loaded, out_data stays stable, no byte is lost; after release both words emerge in order.
- Byte 11 with no sop in IDLE, then a packet 22..25 with a stray sop on byte 33 inserted mid-packet → output is 22232425 only; with STREAM_BYTE_PACKER_ERR_CNT_EN, err_count=2; with err_clear pulsed, err_count=0.
- Assert reset after 3 bytes of a packet, release, send 4-byte packet 0A..0D → only 0A0B0C0D (sop, eop, empty=0) is output; out_valid=0 during reset.
